// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/response bus of the multi-cycle shifter
//  request : in_valid, in_ready, opd1 (value), opd2 (amount), alu_op_select
//  response: out_valid, out_ready, shifter_result, op_err; status: busy
//  master drives requests and takes results; slave is the shifter
interface seq_shifter_if #(parameter int OPD_LENGTH = 8);
  logic                  in_valid;
  logic                  in_ready;
  logic [OPD_LENGTH-1:0] opd1;
  logic [OPD_LENGTH-1:0] opd2;
  logic [3:0]            alu_op_select;
  logic                  out_valid;
  logic                  out_ready;
  logic [OPD_LENGTH-1:0] shifter_result;
  logic                  op_err;
  logic                  busy;
  modport master (
    output in_valid, opd1, opd2, alu_op_select, out_ready,
    input  in_ready, out_valid, shifter_result, op_err, busy
  );
  modport slave (
    input  in_valid, opd1, opd2, alu_op_select, out_ready,
    output in_ready, out_valid, shifter_result, op_err, busy
  );
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle SLL/SRL/SRA/ROL/ROR shifter moving STEP bits per clock
//  clk, rst_n : clock, asynchronous active-low reset
//  bus        : seq_shifter_if.slave (request in, result out, busy status)
module seq_shifter #(
  parameter int OPD_LENGTH = 8,
  parameter int STEP = 1
) (
  input logic clk,
  input logic rst_n,
  seq_shifter_if.slave bus
);
  localparam int SHAMT_W = $clog2(OPD_LENGTH);
  localparam logic [SHAMT_W:0] STEP_K = (SHAMT_W + 1)'(STEP);
  localparam logic [SHAMT_W:0] WIDTH_K = (SHAMT_W + 1)'(OPD_LENGTH);
  localparam logic [3:0] OP_SLL = 4'b0011, OP_SRL = 4'b0001, OP_SRA = 4'b0111,
                         OP_ROL = 4'b1011, OP_ROR = 4'b0101;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t state, state_nx;
  logic [OPD_LENGTH-1:0] data, data_sh, result;
  logic [3:0] op;
  logic [SHAMT_W-1:0] rem, n;
  logic [SHAMT_W:0] k, kc;
  logic fill, err, op_ok, accept, last;
  assign n = bus.opd2[SHAMT_W-1:0];
  assign op_ok = bus.alu_op_select inside {OP_SLL, OP_SRL, OP_SRA, OP_ROL, OP_ROR};
  assign accept = bus.in_valid && state == IDLE;
  // k is one bit wider than rem so STEP == OPD_LENGTH stays representable
  assign k = ({1'b0, rem} < STEP_K) ? {1'b0, rem} : STEP_K;
  assign kc = WIDTH_K - k;
  assign last = k == {1'b0, rem};
  // SRA fills from the captured operand MSB rather than the current data MSB
  always_comb begin
    data_sh = op == OP_SLL ? data << k :
              op == OP_SRL ? data >> k :
              op == OP_SRA ? (data >> k) | (fill ? ~({OPD_LENGTH{1'b1}} >> k) : '0) :
              op == OP_ROL ? (data << k) | (data >> kc) :
                             (data >> k) | (data << kc);
  end
  always_comb begin
    state_nx = state;
    state_nx = state == IDLE  ? (bus.in_valid ? ((n == '0 || !op_ok) ? DONE : SHIFT) : IDLE) :
               state == SHIFT ? (last ? DONE : SHIFT) :
                                (bus.out_ready ? IDLE : DONE);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data <= '0;
      op <= '0;
      rem <= '0;
      fill <= 1'b0;
      result <= '0;
      err <= 1'b0;
    end else if (accept) begin
      data <= bus.opd1;
      op <= bus.alu_op_select;
      rem <= n;
      fill <= bus.opd1[OPD_LENGTH-1];
      if (n == '0 || !op_ok) begin
        result <= op_ok ? bus.opd1 : '0;
        err <= !op_ok;
      end
    end else if (state == SHIFT) begin
      data <= data_sh;
      rem <= rem - k[SHAMT_W-1:0];
      if (last) begin
        result <= data_sh;
        err <= 1'b0;
      end
    end
  end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.busy = state != IDLE;
  assign bus.shifter_result = result;
  assign bus.op_err = err;
endmodule

// File: tb/tb_seq_shifter.sv
// tb_seq_shifter: scoreboard bench for seq_shifter at STEP=2 and STEP=1
module tb_seq_shifter;
  localparam int W = 8;
  logic clk = 0, rst_n = 1;
  logic iv = 0, sel = 0, ordy = 1, hold = 0, rmode = 0;
  logic [W-1:0] a = 0, b = 0;
  logic [3:0] opc = 0;
  logic rdy_s, ov_s, err_s, busy_s;
  logic [W-1:0] res_s;
  int total = 0, bad = 0, cyc = 0, acc = 0;
  typedef struct {logic [W-1:0] res; logic err; int lat;} exp_t;
  exp_t q[$];
  exp_t cur;
  bit have = 0;
  logic [3:0] codes [5] = '{4'b0011, 4'b0001, 4'b0111, 4'b1011, 4'b0101};
  always #5 clk = ~clk;
  seq_shifter_if #(.OPD_LENGTH(W)) ia();
  seq_shifter_if #(.OPD_LENGTH(W)) ib();
  seq_shifter #(.OPD_LENGTH(W), .STEP(2)) u_a (.clk(clk), .rst_n(rst_n), .bus(ia.slave));
  seq_shifter #(.OPD_LENGTH(W), .STEP(1)) u_b (.clk(clk), .rst_n(rst_n), .bus(ib.slave));
  assign ia.in_valid = iv & ~sel;
  assign ib.in_valid = iv & sel;
  assign ia.opd1 = a;
  assign ib.opd1 = a;
  assign ia.opd2 = b;
  assign ib.opd2 = b;
  assign ia.alu_op_select = opc;
  assign ib.alu_op_select = opc;
  assign ia.out_ready = ordy;
  assign ib.out_ready = ordy;
  assign rdy_s = sel ? ib.in_ready : ia.in_ready;
  assign ov_s = sel ? ib.out_valid : ia.out_valid;
  assign err_s = sel ? ib.op_err : ia.op_err;
  assign busy_s = sel ? ib.busy : ia.busy;
  assign res_s = sel ? ib.shifter_result : ia.shifter_result;
  function automatic void chk(string nm, int got, int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, got, want, $time);
    end
  endfunction
  function automatic exp_t model(logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y, int step);
    exp_t e;
    int n = int'(y) % W;
    int ux = int'(x);
    int sx = x[W-1] ? ux - (1 << W) : ux;
    int v;
    e.err = 0;
    e.lat = (n + step - 1) / step;
    case (o)
      4'b0011: v = ux << n;
      4'b0001: v = ux >> n;
      4'b0111: v = sx >>> n;
      4'b1011: v = (ux << n) | (ux >> (W - n));
      4'b0101: v = (ux >> n) | (ux << (W - n));
      default: begin v = 0; e.err = 1; e.lat = 0; end
    endcase
    e.res = v[W-1:0];
    return e;
  endfunction
  task automatic send(logic s, logic [3:0] o, logic [W-1:0] x, logic [W-1:0] y);
    int t = 0;
    @(posedge clk); #1;
    sel = s; opc = o; a = x; b = y; iv = 1;
    @(negedge clk);
    while (!rdy_s && t < 200) begin @(negedge clk); t++; end
    if (!rdy_s) chk("accept_timeout", 0, 1);
    else q.push_back(model(o, x, y, s ? 1 : 2));
    @(posedge clk); #1 iv = 0;
  endtask
  task automatic drain();
    int t = 0;
    while ((q.size() > 0 || ov_s) && t < 500) begin @(negedge clk); t++; end
    if (t >= 500) chk("drain_timeout", q.size(), 0);
  endtask
  initial forever begin
    @(posedge clk);
    cyc++;
  end
  initial forever begin
    @(posedge clk); #1;
    ordy = hold ? 1'b0 : (rmode ? 1'($urandom % 2) : 1'b1);
  end
  initial forever begin
    @(negedge clk);
    if (!rst_n) have = 0;
    else begin
      if (iv && rdy_s) acc = cyc;
      if (ov_s) begin
        if (!have) begin
          if (q.size() == 0) chk("unexpected_out_valid", 1, 0);
          else begin
            cur = q.pop_front();
            have = 1;
            chk("result", res_s, cur.res);
            chk("op_err", err_s, cur.err);
            chk("latency", cyc - acc - 1, cur.lat);
          end
        end else begin
          chk("held_result", res_s, cur.res);
          chk("held_err", err_s, cur.err);
        end
        if (ordy) have = 0;
      end
    end
  end
  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int t;
    #1 rst_n = 0;
    #2;
    chk("rst_in_ready", rdy_s, 1);
    chk("rst_out_valid", ov_s, 0);
    chk("rst_result", res_s, 0);
    chk("rst_op_err", err_s, 0);
    chk("rst_busy", busy_s, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    send(0, 4'b0011, 8'h0f, 8'h03);
    send(0, 4'b0001, 8'hf0, 8'h03);
    send(0, 4'b0111, 8'he0, 8'h03);
    send(0, 4'b0101, 8'h81, 8'h01);
    send(0, 4'b1011, 8'h81, 8'h07);
    send(0, 4'b0011, 8'h01, 8'h0b);
    send(0, 4'b0001, 8'ha5, 8'h00);
    send(0, 4'b0000, 8'ha5, 8'h03);
    drain();
    hold = 1;
    send(0, 4'b0011, 8'h0f, 8'h03);
    t = 0;
    while (!ov_s && t < 50) begin @(negedge clk); t++; end
    chk("stall_out_valid", ov_s, 1);
    repeat (3) begin
      @(posedge clk); #1;
      iv = 1; a = 8'h3c; b = 8'h01; opc = 4'b0001;
      @(negedge clk);
      chk("stall_in_ready", rdy_s, 0);
      chk("stall_busy", busy_s, 1);
      chk("stall_result", res_s, 8'h78);
    end
    @(posedge clk); #1;
    iv = 0; hold = 0;
    t = 0;
    while (ov_s && t < 50) begin @(negedge clk); t++; end
    chk("handoff_in_ready", rdy_s, 1);
    chk("handoff_out_valid", ov_s, 0);
    send(0, 4'b1011, 8'h81, 8'h07);
    #3 rst_n = 0;
    #1;
    q.delete();
    chk("midrst_in_ready", rdy_s, 1);
    chk("midrst_out_valid", ov_s, 0);
    chk("midrst_result", res_s, 0);
    chk("midrst_op_err", err_s, 0);
    chk("midrst_busy", busy_s, 0);
    repeat (2) @(negedge clk);
    #1 rst_n = 1;
    repeat (6) begin
      @(negedge clk);
      chk("no_valid_after_reset", ov_s, 0);
    end
    rmode = 1;
    for (int i = 0; i < 60; i++) begin
      logic [3:0] o;
      o = ($urandom % 6 == 5) ? 4'($urandom) : codes[$urandom % 5];
      send(0, o, 8'($urandom), 8'($urandom));
    end
    drain();
    for (int o = 0; o < 5; o++)
      for (int n = 0; n < 8; n++)
        send(1, codes[o], 8'($urandom), 8'(n));
    send(1, 4'b1111, 8'h5a, 8'h04);
    drain();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
